// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for the N-to-1 arbitrating multiplexer: per-channel
// inputs with ready/valid, arbitration controls and a single registered output.
interface mux_arb_nto1_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic              mode;
  logic [SELW-1:0]   select;
  logic [DW-1:0]     out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 multiplexer with fixed-select or round-robin arbitration feeding a
// single output register (1-cycle latency, full throughput, no bubble).
module mux_arb_nto1 #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_arb_nto1_if.slave  bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SELW-1:0] LAST_RST = SELW'(NCH - 1);

  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] last_q, last_d;

  logic            ld;
  logic            acc;
  logic            fix_vld, rr_vld, gnt_vld;
  logic [SELW-1:0] fix_idx, rr_idx, gnt_idx, cand;
  logic [DW-1:0]   gnt_data;

  // Fixed select: an out-of-range or idle selected channel blocks all others.
  always_comb begin
    fix_idx = bus.select;
    fix_vld = 1'b0;
    if (int'(bus.select) < NCH) begin
      fix_vld = bus.in_valid[bus.select];
    end
  end

  always_comb begin
    rr_vld = 1'b0;
    rr_idx = last_q;
    cand   = last_q;
    for (int k = 1; k <= NCH; k++) begin
      cand = SELW'((int'(last_q) + k) % NCH);
      if (!rr_vld && bus.in_valid[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign gnt_vld  = bus.mode ? rr_vld : fix_vld;
  assign gnt_idx  = bus.mode ? rr_idx : fix_idx;
  assign gnt_data = bus.in_data[gnt_idx*DW +: DW];

  assign ld  = !out_valid_q || bus.out_ready;
  assign acc = ld && gnt_vld && !rst;

  always_comb begin
    bus.in_ready = '0;
    if (acc) begin
      bus.in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (ld) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_chan_d  = gnt_idx;
        out_valid_d = 1'b1;
        if (bus.mode) begin
          last_d = gnt_idx;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register stage; reset discards any held word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed and randomized checks of mux_arb_nto1 against a transaction-level
// model of the arbitration and output register.
module tb_mux_arb_nto1;
  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int SELW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_arb_nto1_if #(.NCH(NCH), .DW(DW)) bus ();
  mux_arb_nto1 #(.NCH(NCH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_chan;
  int            m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = NCH - 1;
  endtask

  // Channel that should win given the current inputs, or -1 for none.
  function automatic int model_grant();
    int order[$];
    if (bus.mode == 1'b0) begin
      if (int'(bus.select) < NCH && bus.in_valid[bus.select]) return int'(bus.select);
      return -1;
    end
    for (int k = 1; k <= NCH; k++) order.push_back((m_last + k) % NCH);
    foreach (order[i]) if (bus.in_valid[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic cycle();
    int            g;
    logic          ld;
    logic [NCH-1:0] exp_rdy;
    logic [DW-1:0] word;
    #1;
    g  = model_grant();
    ld = !m_valid || bus.out_ready;
    exp_rdy = '0;
    word    = '0;
    if (ld && g >= 0) begin
      exp_rdy[g] = 1'b1;
      word = bus.in_data[g*DW +: DW];
    end
    chk("in_ready", bus.in_ready, exp_rdy);
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = word;
        m_chan  = g;
        if (bus.mode) m_last = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_data",  bus.out_data,  m_data);
    chk("out_chan",  bus.out_chan,  m_chan);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    logic [DW-1:0]   held_d;
    logic [SELW-1:0] held_c;

    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.select    = 2'd0;
    bus.in_valid  = '1;
    bus.in_data   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    bus.out_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data",  bus.out_data,  8'h00);
    chk("rst_chan",  bus.out_chan,  2'd0);
    chk("rst_ready", bus.in_ready,  4'b0000);
    #4 rst = 1'b0;

    // Fixed select of channel 2, first grant right after reset release.
    bus.select = 2'd2;
    #1 chk("r030_ready", bus.in_ready, 4'b0100);
    cycle();
    chk("r030_data",  bus.out_data,  8'hC3);
    chk("r030_chan",  bus.out_chan,  2'd2);
    chk("r030_valid", bus.out_valid, 1'b1);

    // Round-robin over all channels starting at 0.
    bus.mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      seq.push_back(int'(bus.out_chan));
    end
    chk("r031_seq0", seq[0], 0);
    chk("r031_seq1", seq[1], 1);
    chk("r031_seq2", seq[2], 2);
    chk("r031_seq3", seq[3], 3);
    chk("r031_seq4", seq[4], 0);

    // Only channels 1 and 3 offer words.
    bus.in_valid = 4'b1010;
    seq.delete();
    for (int i = 0; i < 4; i++) begin
      #1 chk("r032_no02", bus.in_ready & 4'b0101, 4'b0000);
      cycle();
      seq.push_back(int'(bus.out_chan));
    end
    chk("r032_seq0", seq[0], 1);
    chk("r032_seq1", seq[1], 3);
    chk("r032_seq2", seq[2], 1);
    chk("r032_seq3", seq[3], 3);

    // Backpressure holds the word; release transfers and reloads in one edge.
    bus.in_valid  = '1;
    bus.out_ready = 1'b0;
    held_d = bus.out_data;
    held_c = bus.out_chan;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r033_hold_d", bus.out_data, held_d);
      chk("r033_hold_c", bus.out_chan, held_c);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("r033_next_c", bus.out_chan,  2'd0);
    chk("r033_next_v", bus.out_valid, 1'b1);

    // Selected channel idle: nobody else may be granted.
    bus.mode     = 1'b0;
    bus.select   = 2'd1;
    bus.in_valid = 4'b1101;
    #1 chk("r034_ready", bus.in_ready, 4'b0000);
    cycle();
    cycle();
    chk("r034_valid", bus.out_valid, 1'b0);

    // Async reset between edges drops the held word immediately.
    bus.mode      = 1'b1;
    bus.in_valid  = '1;
    bus.out_ready = 1'b0;
    cycle();
    chk("r035_pre", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("r035_valid", bus.out_valid, 1'b0);
    chk("r035_data",  bus.out_data,  8'h00);
    chk("r035_ready", bus.in_ready,  4'b0000);
    #1 rst = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    cycle();
    chk("r035_restart", bus.out_chan, 2'd0);

    for (int i = 0; i < 400; i++) begin
      bus.mode      = 1'($urandom_range(0, 1));
      bus.select    = SELW'($urandom_range(0, NCH - 1));
      bus.in_valid  = NCH'($urandom);
      bus.in_data   = (NCH*DW)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
